// File: rtl/pipeline_pkg.sv
// Shared pipeline types and widths for the fetch stage and its queue storage.
package pipeline_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc4;
  } fetch_entry_t;

  // Sequential fetch address; plain 32-bit add wraps 32'hFFFF_FFFC to 0.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side bundle: instruction-memory address/data, EX redirect, and decode handshake.
interface fetch_queue_if #(parameter int DEPTH = 4);
  import pipeline_pkg::*;

  logic [PC_W-1:0]              FetchPC;
  logic [INSTR_W-1:0]           InstrIn;
  logic                         Redirect;
  logic [PC_W-1:0]              RedirectPC;
  logic                         DecReady;
  logic                         DecValid;
  logic [INSTR_W-1:0]           InstructionOut;
  logic [PC_W-1:0]              PC4Out;
  logic                         Full;
  logic                         Empty;
  logic [$clog2(DEPTH+1)-1:0]   Count;

  modport master (
    input  InstrIn, Redirect, RedirectPC, DecReady,
    output FetchPC, DecValid, InstructionOut, PC4Out, Full, Empty, Count
  );

  modport slave (
    output InstrIn, Redirect, RedirectPC, DecReady,
    input  FetchPC, DecValid, InstructionOut, PC4Out, Full, Empty, Count
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// Entry storage for the fetch queue: one synchronous write port, one asynchronous read port.
module fetch_queue_ram
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fetch_entry_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fetch_entry_t             rdata
);

  fetch_entry_t mem [DEPTH];

  // NOTE: no reset on the array; an entry is only read after it was written,
  // because the read data is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequentially, buffers DEPTH entries, flushes on redirect.
// Optional zero-latency empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input logic          Clk,
  input logic          Rst,
  fetch_queue_if.master fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [PC_W-1:0]  fetch_pc, pc_plus4;
  logic             empty, full, push, pop, bypass;
  fetch_entry_t     wr_entry, rd_entry;
  logic             unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^fq.RedirectPC[1:0];

  assign pc_plus4 = next_pc(fetch_pc);
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);

`ifdef FETCH_QUEUE_BYPASS_EN
  // Gated by Rst so the reset-time outputs stay at zero/invalid.
  assign bypass = empty && !fq.Redirect && fq.DecReady && !Rst;
`else
  assign bypass = 1'b0;
`endif

  assign push = !full && !fq.Redirect && !bypass;
  assign pop  = !empty && !fq.Redirect && fq.DecReady;

  assign wr_entry = '{instr: fq.InstrIn, pc4: pc_plus4};

  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (Clk),
    .we    (push),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (rd_entry)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (fq.Redirect) begin
      fetch_pc <= {fq.RedirectPC[PC_W-1:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push || bypass) fetch_pc <= pc_plus4;
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    fq.DecValid       = !empty && !fq.Redirect;
    fq.InstructionOut = empty ? NOP_INSTR : rd_entry.instr;
    fq.PC4Out         = empty ? '0 : rd_entry.pc4;
    if (bypass) begin
      fq.DecValid       = 1'b1;
      fq.InstructionOut = fq.InstrIn;
      fq.PC4Out         = pc_plus4;
    end
  end

  assign fq.FetchPC = fetch_pc;
  assign fq.Full    = full;
  assign fq.Empty   = empty;
  assign fq.Count   = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default build, no bypass).
module tb_fetch_queue;
  import pipeline_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(4)) fq_a ();
  fetch_queue_if #(.DEPTH(4)) fq_b ();

  // Instruction memory model: a distinct, nonzero word per address.
  function automatic logic [31:0] imem(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  assign fq_a.InstrIn = imem(fq_a.FetchPC);
  assign fq_b.InstrIn = imem(fq_b.FetchPC);

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut_a (
    .Clk (clk), .Rst (rst), .fq (fq_a.master)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .Clk (clk), .Rst (rst), .fq (fq_b.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    fq_a.Redirect   = 1'b0;
    fq_a.RedirectPC = '0;
    fq_a.DecReady   = 1'b0;
    fq_b.Redirect   = 1'b0;
    fq_b.RedirectPC = '0;
    fq_b.DecReady   = 1'b1;

    // Reset state
    step();
    check("rst_fetchpc", fq_a.FetchPC, 32'h0);
    check("rst_count",   32'(fq_a.Count), 32'd0);
    check("rst_empty",   32'(fq_a.Empty), 32'd1);
    check("rst_full",    32'(fq_a.Full), 32'd0);
    check("rst_valid",   32'(fq_a.DecValid), 32'd0);
    check("rst_instr",   fq_a.InstructionOut, 32'h0);
    check("rst_pc4",     fq_a.PC4Out, 32'h0);
    check("rst_b_fetchpc", fq_b.FetchPC, 32'hFFFF_FFF8);
    check("rst_b_valid", 32'(fq_b.DecValid), 32'd0);
    step();
    rst = 1'b0;

    // Fill with decode stalled: FetchPC 0,4,8,12,16,16,16
    check("fill_pc0", fq_a.FetchPC, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("fill_pc%0d", i), fq_a.FetchPC, (i < 4) ? 32'(4 * i) : 32'd16);
      if (i == 1) begin
        check("lat_valid", 32'(fq_a.DecValid), 32'd1);
        check("lat_pc4",   fq_a.PC4Out, 32'h4);
        check("lat_instr", fq_a.InstructionOut, imem(32'h0));
        check("wrap_pc4_0", fq_b.PC4Out, 32'hFFFF_FFFC);
        check("wrap_valid", 32'(fq_b.DecValid), 32'd1);
      end else if (i == 2) begin
        check("wrap_pc4_1",  fq_b.PC4Out, 32'h0000_0000);
        check("wrap_instr1", fq_b.InstructionOut, imem(32'hFFFF_FFFC));
      end else if (i == 3) begin
        check("wrap_pc4_2", fq_b.PC4Out, 32'h0000_0004);
        check("wrap_count", 32'(fq_b.Count), 32'd1);
      end
    end
    check("full_flag",  32'(fq_a.Full), 32'd1);
    check("full_count", 32'(fq_a.Count), 32'd4);

    // One pop while full: no push that cycle
    fq_a.DecReady = 1'b1;
    check("pop_instr", fq_a.InstructionOut, imem(32'h0));
    check("pop_pc4",   fq_a.PC4Out, 32'h4);
    step();
    fq_a.DecReady = 1'b0;
    check("pop_count",   32'(fq_a.Count), 32'd3);
    check("pop_fetchpc", fq_a.FetchPC, 32'd16);
    check("pop_next_pc4", fq_a.PC4Out, 32'h8);

    // Redirect with misaligned target flushes everything
    fq_a.Redirect   = 1'b1;
    fq_a.RedirectPC = 32'h0000_0043;
    #1;
    check("redir_valid_low", 32'(fq_a.DecValid), 32'd0);
    step();
    fq_a.Redirect = 1'b0;
    check("redir_count",   32'(fq_a.Count), 32'd0);
    check("redir_empty",   32'(fq_a.Empty), 32'd1);
    check("redir_fetchpc", fq_a.FetchPC, 32'h40);
    check("redir_instr",   fq_a.InstructionOut, 32'h0);
    step();
    check("redir_pc4",   fq_a.PC4Out, 32'h44);
    check("redir_instr_out", fq_a.InstructionOut, imem(32'h40));

    // Steady streaming: one per cycle, Count stays 1, across pointer wrap
    fq_a.DecReady = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("stream_pc4_%0d", k), fq_a.PC4Out, 32'h44 + 32'(4 * k));
      check($sformatf("stream_instr_%0d", k), fq_a.InstructionOut, imem(32'h40 + 32'(4 * k)));
      check($sformatf("stream_count_%0d", k), 32'(fq_a.Count), 32'd1);
      step();
    end

    // Stall one cycle to reach Count=2, then reset mid-cycle
    fq_a.DecReady = 1'b0;
    step();
    check("pre_rst_count", 32'(fq_a.Count), 32'd2);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(fq_a.DecValid), 32'd0);
    check("async_rst_pc4",   fq_a.PC4Out, 32'h0);
    check("async_rst_instr", fq_a.InstructionOut, 32'h0);
    check("async_rst_count", 32'(fq_a.Count), 32'd0);
    check("async_rst_pc",    fq_a.FetchPC, 32'h0);
    #2;
    rst = 1'b0;
    fq_a.DecReady = 1'b1;
    #1;
    check("post_rst_valid", 32'(fq_a.DecValid), 32'd0);
    step();
    check("post_rst_pc4",   fq_a.PC4Out, 32'h4);
    check("post_rst_instr", fq_a.InstructionOut, imem(32'h0));
    check("post_rst_count", 32'(fq_a.Count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count; power of two, >=2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port Clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port Rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port FetchPC, output, 32, registered address to InstructionMemory.
REQ-006 SHALL have port InstrIn, input, 32, InstructionMemory data for FetchPC, same cycle.
REQ-007 SHALL have port Redirect, input, 1, branch/jump/jr taken from EX stage.
REQ-008 SHALL have port RedirectPC, input, 32, new fetch target; bits [1:0] ignored, treated as 00.
REQ-009 SHALL have port DecReady, input, 1, decode stage accepts head entry this cycle.
REQ-010 SHALL have port DecValid, output, 1, InstructionOut/PC4Out valid.
REQ-011 SHALL have port InstructionOut, output, 32, head instruction to FE_DEC pipeline register.
REQ-012 SHALL have port PC4Out, output, 32, head instruction address + 4.
REQ-013 SHALL have ports Full, output, 1 and Empty, output, 1, occupancy flags from registered count.
REQ-014 SHALL have port Count, output, $clog2(DEPTH+1), registered occupancy.

Function
REQ-015 Push: when !Full and !Redirect, SHALL write {InstrIn, FetchPC+4} at tail, tail+1 mod DEPTH, FetchPC <= FetchPC+4.
REQ-016 When Full, SHALL hold FetchPC and not push, even if a pop occurs the same cycle.
REQ-017 Pop: when DecValid and DecReady and !Redirect, SHALL advance head mod DEPTH.
REQ-018 Simultaneous push and pop SHALL leave Count unchanged.
REQ-019 DecValid SHALL equal !Empty && !Redirect (non-bypass build).
REQ-020 When Empty, InstructionOut and PC4Out SHALL be 32'h0 (NOP).
REQ-021 Redirect SHALL, in one cycle, flush all entries (head=tail=0, Count=0), set FetchPC <= {RedirectPC[31:2],2'b00}, suppress push and pop.
REQ-022 Latency: instruction fetched in cycle N SHALL be presented with DecValid=1 in cycle N+1 at the earliest.
REQ-023 FetchPC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 Entries SHALL leave in fetch order; no entry SHALL be duplicated or dropped except by Redirect.

Reset
REQ-025 Rst high SHALL immediately force FetchPC=RESET_PC, head=tail=0, Count=0, Empty=1, Full=0, DecValid=0, InstructionOut=0, PC4Out=0.
REQ-026 Storage array SHALL NOT require reset; contents unobservable while Empty.
REQ-027 Rst asserted mid-operation SHALL discard all entries; first push after release SHALL use RESET_PC.

Configuration
REQ-028 Macro FETCH_QUEUE_BYPASS_EN defined: when Empty, !Redirect, DecReady, SHALL drive InstrIn/FetchPC+4 straight to outputs with DecValid=1, advance FetchPC, not write queue (zero-cycle latency).
REQ-029 Macro undefined: no bypass path; REQ-019/REQ-022 apply unchanged.

Structure
REQ-030 Package pipeline_pkg SHALL hold INSTR_W=32, PC_W=32, NOP_INSTR=32'h0, and the fetch_entry_t {instr, pc4} typedef.
REQ-031 Storage SHALL be sub-module fetch_queue_ram (DEPTH x 64, 1 write port, 1 async read port, no reset).

Verification
REQ-032 Reset release, DecReady=0 for 6 cycles -> FetchPC 0,4,8,12 then holds 16; Full=1, Count=4.
REQ-033 Queue full, DecReady=1 one cycle -> InstructionOut=mem[0], PC4Out=4; Count 3 next cycle; next push at FetchPC=16.
REQ-034 Steady DecReady=1 -> one instruction per cycle, PC4Out 4,8,12,... consecutive, Count stays 1.
REQ-035 Count=3, Redirect=1, RedirectPC=32'h0000_0043 -> next cycle Count=0, Empty=1, FetchPC=32'h40; following cycle PC4Out=32'h44.
REQ-036 RESET_PC=32'hFFFF_FFF8, DecReady=1 -> PC4Out sequence FFFF_FFFC, 0000_0000, 0000_0004.
REQ-037 Rst pulsed mid-cycle with Count=2 -> outputs zero asynchronously, no entry emitted after release before re-fetch from RESET_PC; with FETCH_QUEUE_BYPASS_EN, DecValid=1 in first cycle after release.
